cruise_regulator: RTL and testbench

Parametrised closed-loop cruise regulator and the next generation of the `control` cruise-control FSM. It takes the measured speed directly and latches a driver-selected target, so the comparator is internal instead of three external `gt`/`eq`/`lt` strobes. It adds a hysteresis band, rate-limited fuel injection (`pashesh`), engine-braking-before-brake sequencing, and a driver-alertness (`hooshyari`) watchdog that forces a safe stop. It sits between the speed sensor/driver controls and the throttle/brake actuators.

---
 rtl/cruise_regulator.sv | 124 ++++++++++++
 tb/tb_cruise_regulator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cruise_regulator.sv
// Closed-loop cruise regulator: latches a target speed on engage and ramps fuel
// injection (pashesh) by one LSB per cycle to hold it inside a dead band.
// It uses engine braking before the brake (tormoz) and runs a driver-alertness
// (hooshyari) watchdog that forces a safe stop.
// Latency: one cycle; every output is a flop, with no combinational input-to-output path.
// Backpressure: none; inputs are sampled on every clock edge.
// Ports: clock/reset_n (async active-low); engage/cancel/brake_pedal driver controls;
//   speed measured speed; hooshyari alertness; active/target/pashesh/tormoz/drowsy outputs.
module cruise_regulator #(
  parameter int SPEED_W       = 8,
  parameter int INJ_W         = 3,
  parameter int ALERT_W       = 3,
  parameter int HYST          = 2,
  parameter int ALERT_MIN     = 2,
  parameter int DROWSY_CYCLES = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               engage,
  input  logic               cancel,
  input  logic               brake_pedal,
  input  logic [SPEED_W-1:0] speed,
  input  logic [ALERT_W-1:0] hooshyari,
  output logic               active,
  output logic [SPEED_W-1:0] target,
  output logic [INJ_W-1:0]   pashesh,
  output logic               tormoz,
  output logic               drowsy
);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_ACCEL, S_DECEL, S_STOP
  } state_t;

  localparam int                 CNT_W       = $clog2(DROWSY_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX     = CNT_W'(DROWSY_CYCLES);
  localparam logic [SPEED_W-1:0] SPD_MAX     = '1;
  localparam logic [SPEED_W-1:0] HYST_V      = SPEED_W'(HYST);
  localparam logic [INJ_W-1:0]   INJ_MAX     = '1;
  localparam logic [ALERT_W-1:0] ALERT_MIN_V = ALERT_W'(ALERT_MIN);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [SPEED_W-1:0] target_d, lo, hi;
  logic [INJ_W-1:0]   pashesh_d;
  logic               tormoz_d;
  logic               cur_active, low_alert;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      target  <= '0;
      pashesh <= '0;
      tormoz  <= 1'b0;
      active  <= 1'b0;
      drowsy  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      target  <= target_d;
      pashesh <= pashesh_d;
      tormoz  <= tormoz_d;
      active  <= (state_d == S_HOLD) || (state_d == S_ACCEL) || (state_d == S_DECEL);
      drowsy  <= (state_d == S_STOP);
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target;
    pashesh_d = pashesh;
    tormoz_d  = 1'b0;
    cnt_d     = '0;

    // Band limits are compared before any arithmetic so they clamp instead of wrapping.
    lo = (target >= HYST_V) ? (target - HYST_V) : '0;
    hi = (target > (SPD_MAX - HYST_V)) ? SPD_MAX : (target + HYST_V);

    cur_active = (state_q == S_HOLD) || (state_q == S_ACCEL) || (state_q == S_DECEL);
    low_alert  = (hooshyari < ALERT_MIN_V);

    // Counter value including this edge's sample; it trips the watchdog when it hits the limit.
    if (cur_active && low_alert)
      cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + 1'b1);
    else
      cnt_inc = '0;

    if (cancel || brake_pedal)
      state_d = S_IDLE;
    else if (state_q == S_STOP)
      state_d = (speed == '0) ? S_IDLE : S_STOP;
    else if (cur_active && (cnt_inc == CNT_MAX))
      state_d = S_STOP;
    else if (engage && !low_alert) begin
      state_d  = S_HOLD;
      target_d = speed;
    end else if (cur_active) begin
      if (speed < lo)      state_d = S_ACCEL;
      else if (speed > hi) state_d = S_DECEL;
      else                 state_d = S_HOLD;
    end else
      state_d = S_IDLE;

    case (state_d)
      S_ACCEL: if (pashesh != INJ_MAX) pashesh_d = pashesh + 1'b1;
      S_DECEL: begin
        // Engine braking first: the brake only engages once injection is already zero.
        if (pashesh != '0) pashesh_d = pashesh - 1'b1;
        tormoz_d = (pashesh == '0);
      end
      S_HOLD:  pashesh_d = pashesh;
      S_STOP: begin
        pashesh_d = '0;
        tormoz_d  = 1'b1;
      end
      default: pashesh_d = '0;
    endcase

    if ((state_d == S_HOLD) || (state_d == S_ACCEL) || (state_d == S_DECEL))
      cnt_d = cnt_inc;
  end

endmodule

// File: tb/tb_cruise_regulator.sv
module tb_cruise_regulator;

  localparam int SPEED_W = 8, INJ_W = 3, ALERT_W = 3;
  localparam int HYST = 2, ALERT_MIN = 2, DROWSY_CYCLES = 8;
  localparam int SPD_MAX = 255, INJ_MAX = 7;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               engage = 1'b0, cancel = 1'b0, brake_pedal = 1'b0;
  logic [SPEED_W-1:0] speed = '0;
  logic [ALERT_W-1:0] hooshyari = 3'd5;
  logic               active, tormoz, drowsy;
  logic [SPEED_W-1:0] target;
  logic [INJ_W-1:0]   pashesh;

  int checks = 0;
  int failures = 0;

  cruise_regulator #(
    .SPEED_W(SPEED_W), .INJ_W(INJ_W), .ALERT_W(ALERT_W), .HYST(HYST),
    .ALERT_MIN(ALERT_MIN), .DROWSY_CYCLES(DROWSY_CYCLES)
  ) dut (
    .clock(clock), .reset_n(reset_n), .engage(engage), .cancel(cancel),
    .brake_pedal(brake_pedal), .speed(speed), .hooshyari(hooshyari),
    .active(active), .target(target), .pashesh(pashesh), .tormoz(tormoz),
    .drowsy(drowsy)
  );

  always #5 clock = ~clock;

  // Behavioural model: regulating / stopping flags, latched target, injection level,
  // and the length of the current run of drowsy cycles while regulating.
  bit m_on, m_stop, m_brake;
  int m_target, m_inj, m_sleepy;

  task automatic m_reset();
    m_on = 0; m_stop = 0; m_brake = 0; m_target = 0; m_inj = 0; m_sleepy = 0;
  endtask

  task automatic m_step();
    bit sleepy_now;
    int lo, hi, run, spd;
    string kind;
    spd = int'(speed);
    sleepy_now = int'(hooshyari) < ALERT_MIN;
    lo = (m_target - HYST < 0) ? 0 : m_target - HYST;
    hi = (m_target + HYST > SPD_MAX) ? SPD_MAX : m_target + HYST;
    run = (m_on && sleepy_now) ? ((m_sleepy + 1 > DROWSY_CYCLES) ? DROWSY_CYCLES : m_sleepy + 1) : 0;
    if (cancel || brake_pedal)                 kind = "off";
    else if (m_stop)                           kind = (spd == 0) ? "off" : "stop";
    else if (m_on && run >= DROWSY_CYCLES)     kind = "stop";
    else if (engage && !sleepy_now) begin      kind = "hold"; m_target = spd; end
    else if (m_on)                             kind = (spd < lo) ? "up" : (spd > hi) ? "down" : "hold";
    else                                       kind = "off";
    m_brake = (kind == "stop") || (kind == "down" && m_inj == 0);
    if (kind == "up")        m_inj = (m_inj < INJ_MAX) ? m_inj + 1 : INJ_MAX;
    else if (kind == "down") m_inj = (m_inj > 0) ? m_inj - 1 : 0;
    else if (kind != "hold") m_inj = 0;
    m_on = (kind == "hold") || (kind == "up") || (kind == "down");
    m_stop = (kind == "stop");
    m_sleepy = m_on ? run : 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the applied inputs, then compare after the edge.
  task automatic tick(input string nm);
    m_step();
    @(posedge clock);
    #1;
    chk({nm, "_active"},  32'(active),  32'(m_on));
    chk({nm, "_target"},  32'(target),  32'(m_target));
    chk({nm, "_pashesh"}, 32'(pashesh), 32'(m_inj));
    chk({nm, "_tormoz"},  32'(tormoz),  32'(m_brake));
    chk({nm, "_drowsy"},  32'(drowsy),  32'(m_stop));
  endtask

  task automatic drive(input bit e, input bit c, input bit b, input int s, input int h);
    engage = e; cancel = c; brake_pedal = b; speed = SPEED_W'(s); hooshyari = ALERT_W'(h);
  endtask

  typedef struct {
    bit eng, can, brk;
    int spd, hoo;
    int a, tg, p, t, d;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit e, input int s, input int a, input int tg, input int p, input int t);
    vec_t v;
    v.eng = e; v.can = 0; v.brk = 0; v.spd = s; v.hoo = 5;
    v.a = a; v.tg = tg; v.p = p; v.t = t; v.d = 0;
    vecs.push_back(v);
  endtask

  initial begin
    int spd, hoo_mode;
    m_reset();

    // Reset state, held asynchronously before any clock activity matters.
    #2;
    chk("reset_active", 32'(active), 0);
    chk("reset_target", 32'(target), 0);
    chk("reset_pashesh", 32'(pashesh), 0);
    chk("reset_tormoz", 32'(tormoz), 0);
    chk("reset_drowsy", 32'(drowsy), 0);
    #10 reset_n = 1'b1;
    @(posedge clock); #1;

    // Engage, accelerate to saturation, hold, then decelerate into engine braking and brake.
    add(1, 60, 1, 60, 0, 0);
    for (int p = 1; p <= 7; p++) add(0, 57, 1, 60, p, 0);
    add(0, 57, 1, 60, 7, 0);
    add(0, 57, 1, 60, 7, 0);
    add(0, 60, 1, 60, 7, 0);
    for (int p = 6; p >= 3; p--) add(0, 63, 1, 60, p, 0);
    add(0, 60, 1, 60, 3, 0);
    for (int p = 2; p >= 0; p--) add(0, 63, 1, 60, p, 0);
    add(0, 63, 1, 60, 0, 1);
    add(0, 63, 1, 60, 0, 1);
    add(0, 62, 1, 60, 0, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].eng, vecs[i].can, vecs[i].brk, vecs[i].spd, vecs[i].hoo);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_dir_active", i), 32'(active), 32'(vecs[i].a));
      chk($sformatf("vec%0d_dir_target", i), 32'(target), 32'(vecs[i].tg));
      chk($sformatf("vec%0d_dir_pashesh", i), 32'(pashesh), 32'(vecs[i].p));
      chk($sformatf("vec%0d_dir_tormoz", i), 32'(tormoz), 32'(vecs[i].t));
      chk($sformatf("vec%0d_dir_drowsy", i), 32'(drowsy), 32'(vecs[i].d));
    end

    // Alertness watchdog: 7 drowsy cycles are tolerated, the 8th consecutive one trips it.
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 60, 1);
      tick("wd_short");
      chk("wd_short_drowsy", 32'(drowsy), 0);
    end
    drive(0, 0, 0, 60, 4);
    tick("wd_recover");
    chk("wd_recover_active", 32'(active), 1);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 0, 60, 1);
      tick("wd_long");
      chk($sformatf("wd_long%0d_drowsy", i), 32'(drowsy), (i == 8) ? 1 : 0);
    end
    chk("wd_stop_tormoz", 32'(tormoz), 1);
    chk("wd_stop_pashesh", 32'(pashesh), 0);
    chk("wd_stop_active", 32'(active), 0);
    drive(1, 0, 0, 40, 5);
    tick("wd_engage_ignored");
    chk("wd_engage_drowsy", 32'(drowsy), 1);
    chk("wd_engage_target", 32'(target), 60);
    drive(0, 0, 0, 0, 5);
    tick("wd_halt");
    chk("wd_halt_drowsy", 32'(drowsy), 0);
    chk("wd_halt_tormoz", 32'(tormoz), 0);
    chk("wd_halt_active", 32'(active), 0);

    // Driver override: engage with brake, then cancel during acceleration.
    drive(1, 0, 1, 40, 5);
    tick("ovr_engbrk");
    chk("ovr_engbrk_active", 32'(active), 0);
    chk("ovr_engbrk_target", 32'(target), 60);
    drive(1, 0, 0, 60, 5);
    tick("ovr_engage");
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 50, 5);
      tick("ovr_accel");
    end
    chk("ovr_accel_pashesh", 32'(pashesh), 5);
    drive(0, 1, 0, 50, 5);
    tick("ovr_cancel");
    chk("ovr_cancel_pashesh", 32'(pashesh), 0);
    chk("ovr_cancel_active", 32'(active), 0);
    chk("ovr_cancel_target", 32'(target), 60);

    // Band clamps at both ends of the speed range.
    drive(1, 0, 0, 1, 5);
    tick("clamp_lo_eng");
    drive(0, 0, 0, 0, 5);
    tick("clamp_lo");
    tick("clamp_lo2");
    chk("clamp_lo_active", 32'(active), 1);
    chk("clamp_lo_pashesh", 32'(pashesh), 0);
    drive(1, 0, 0, 255, 5);
    tick("clamp_hi_eng");
    drive(0, 0, 0, 255, 5);
    tick("clamp_hi");
    chk("clamp_hi_tormoz", 32'(tormoz), 0);
    chk("clamp_hi_active", 32'(active), 1);
    chk("clamp_hi_target", 32'(target), 255);

    // Asynchronous reset between edges while accelerating.
    drive(1, 0, 0, 60, 5);
    tick("ar_engage");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 50, 5);
      tick("ar_accel");
    end
    #2 reset_n = 1'b0;
    #1;
    chk("ar_active", 32'(active), 0);
    chk("ar_target", 32'(target), 0);
    chk("ar_pashesh", 32'(pashesh), 0);
    chk("ar_tormoz", 32'(tormoz), 0);
    chk("ar_drowsy", 32'(drowsy), 0);
    m_reset();
    #3 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 50, 5);
      tick("ar_idle");
      chk("ar_idle_active", 32'(active), 0);
    end
    drive(1, 0, 0, 60, 5);
    tick("ar_reengage");
    chk("ar_reengage_active", 32'(active), 1);

    // Randomised traffic against the model.
    spd = 60;
    hoo_mode = 0;
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (n % 40 == 0) hoo_mode = int'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) spd = int'($urandom_range(0, 255));
      else if ($urandom_range(0, 99) == 0) spd = 0;
      else spd = spd + int'($urandom_range(0, 4)) - 2;
      if (spd < 0) spd = 0;
      if (spd > 255) spd = 255;
      drive(r < 8, r >= 97, r == 96, spd,
            (hoo_mode == 0) ? int'($urandom_range(0, 1)) :
            (hoo_mode == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(2, 7)));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
